fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the instruction ROM (L1i).
//  Owns the PC, drives the ROM word address and read enable, and captures the ROM's registered read data one cycle later.
//  Presents {instr_out, instr_pc} to decode via valid/ready.
//  Accepts branch/jump redirects.
//  Faults on misaligned or out-of-range PCs.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte address of first fetch
//  ROM_WORDS  32             number of 32-bit words in the instruction ROM (valid word index 0..ROM_WORDS-1)
// PORTS
//  clk              in   1   clock, all state on posedge
//  reset            in   1   synchronous, active-high
//  rom_read_enable  out  1   read strobe to ROM
//  rom_address      out  32  ROM word index = {2'b00, pc[31:2]}
//  rom_data_in      in   32  ROM data_out, valid the cycle after rom_read_enable
//  redirect_valid   in   1   load redirect_pc as next fetch PC
//  redirect_pc      in   32  redirect target (byte address)
//  instr_valid      out  1   instr_out/instr_pc valid for decode
//  instr_ready      in   1   decode accepts when instr_valid & instr_ready
//  instr_out        out  32  fetched instruction word
//  instr_pc         out  32  byte address of instr_out
//  fetch_fault      out  1   sticky: misaligned/out-of-range fetch, stage halted
// BEHAVIOUR
//  - Reset: state=IDLE, pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0.
//  - rom_read_enable is forced 0 while reset is high.
//  - PC check ("bad"): pc[1:0]!=0, or pc[31:2] >= ROM_WORDS.
//  - States:
//    - IDLE: no read.
//      - Next: REQ, or HALT with fetch_fault<=1 if pc is bad.
//    - REQ: rom_read_enable=1, rom_address=pc>>2.
//      - Next: RESP.
//    - RESP: rom_data_in valid this cycle.
//      - Registers instr_out<=rom_data_in, instr_pc<=pc, instr_valid<=1.
//      - Next: HOLD.
//    - HOLD: instr_valid=1; instr_out and instr_pc held stable.
//      - If instr_ready: pc<=pc+4, instr_valid<=0.
//        - If pc+4 is bad: fetch_fault<=1, next HALT, no read issued.
//        - Otherwise: in the same cycle, rom_read_enable=1 and rom_address=(pc+4)>>2 (combinational); next RESP.
//      - If !instr_ready: stay in HOLD, rom_read_enable=0.
//    - HALT: rom_read_enable=0, instr_valid=0. Left only by reset.
//  - Latency and throughput:
//    - First instr_valid occurs in the 4th cycle after reset deasserts (IDLE, REQ, RESP, HOLD).
//    - Steady state with instr_ready=1: one instruction every 2 cycles.
//  - pc+4 is 32-bit modular; a wrap to 0 is caught by the range check only if ROM_WORDS covers it (no special case).
//  - Redirect (any state except HALT, highest priority after reset):
//    - Next cycle: pc<=redirect_pc, instr_valid<=0, state<=REQ.
//    - If redirect_pc is bad: state<=HALT, fetch_fault<=1.
//    - The sequential read for that cycle is suppressed (rom_read_enable=0).
//    - Any in-flight ROM response (redirect during RESP) is discarded, never shown to decode.
//  - Redirect and accept in the same HOLD cycle: the handshake completes (instruction consumed); the redirect then wins over pc+4.
//  - Reset mid-operation: all state returns to reset values next cycle; any in-flight data is dropped.
//  - HALT ignores redirect_valid.
// TESTING
//  - ROM words 0..3 = 0xA0,0xA1,0xA2,0xA3, instr_ready=1 ->
//    - First instr_valid in 4th cycle after reset deassert.
//    - Then valid every 2nd cycle with (instr_pc,instr_out) = (0,0xA0),(4,0xA1),(8,0xA2),(0xC,0xA3).
//  - instr_ready=0 for 5 cycles while valid -> instr_out/instr_pc stable, rom_read_enable=0 throughout.
//    - Raising ready gives the next instr_pc=+4.
//  - redirect_valid=1, redirect_pc=0x10 during RESP of pc=0x4 ->
//    - mem[1] never presented.
//    - Next valid has instr_pc=0x10, instr_out=mem[4].
//  - redirect_pc=0x0000_0006 -> fetch_fault=1 next cycle.
//    - instr_valid=0 and rom_read_enable=0 until reset, even with further redirects.
//  - ROM_WORDS=4: accept instr_pc=0xC -> fetch_fault=1, no read with rom_address=4.
//  - Reset asserted in HOLD (valid=1, pc=0x8) -> next cycle instr_valid=0.
//    - Fetch restarts, first valid has instr_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a registered-output instruction ROM
// and presents each fetched word with its byte address to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ROM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        rom_read_enable,
   output logic [31:0] rom_address,
   input  logic [31:0] rom_data_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        fetch_fault,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RESP = 3'd2,
      S_HOLD = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_instr_out;
   logic [31:0] r_instr_pc;
   logic        r_fault;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic        w_valid_next;
   logic        w_fault_next;
   logic        w_capture;
   logic        w_rd_en;
   logic [31:0] w_rd_addr;
   logic [31:0] w_pc_inc;

   // A PC is unusable if it is not word aligned or points past the last ROM word.
   function automatic logic pc_bad(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(ROM_WORDS));
   endfunction

   assign w_pc_inc = r_pc + 32'd4;

   // Decode handshake: instr_valid stays high with instr_out/instr_pc stable until
   // the cycle where instr_valid & instr_ready are both high; that cycle consumes it.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_valid_next = r_valid;
      w_fault_next = r_fault;
      w_capture    = 1'b0;
      w_rd_en      = 1'b0;
      w_rd_addr    = {2'b00, r_pc[31:2]};
      if (redirect_valid && (r_state != S_HALT)) begin
         // Redirect outranks everything: any in-flight response is simply never captured.
         w_pc_next    = redirect_pc;
         w_valid_next = 1'b0;
         if (pc_bad(redirect_pc)) begin
            w_state_next = S_HALT;
            w_fault_next = 1'b1;
         end else begin
            w_state_next = S_REQ;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (pc_bad(r_pc)) begin
                  w_state_next = S_HALT;
                  w_fault_next = 1'b1;
               end else begin
                  w_state_next = S_REQ;
               end
            end
            S_REQ: begin
               w_rd_en      = 1'b1;
               w_state_next = S_RESP;
            end
            S_RESP: begin
               w_capture    = 1'b1;
               w_valid_next = 1'b1;
               w_state_next = S_HOLD;
            end
            S_HOLD: begin
               if (instr_ready) begin
                  w_pc_next    = w_pc_inc;
                  w_valid_next = 1'b0;
                  if (pc_bad(w_pc_inc)) begin
                     w_state_next = S_HALT;
                     w_fault_next = 1'b1;
                  end else begin
                     // Issue the next read in the accept cycle to sustain one word per 2 cycles.
                     w_rd_en      = 1'b1;
                     w_rd_addr    = {2'b00, w_pc_inc[31:2]};
                     w_state_next = S_RESP;
                  end
               end
            end
            S_HALT: begin
               w_valid_next = 1'b0;
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_valid     <= 1'b0;
         r_instr_out <= 32'd0;
         r_instr_pc  <= 32'd0;
         r_fault     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_valid <= w_valid_next;
         r_fault <= w_fault_next;
         if (w_capture) begin
            r_instr_out <= rom_data_in;
            r_instr_pc  <= r_pc;
         end
      end
   end

   assign rom_read_enable = w_rd_en & ~reset;
   assign rom_address     = w_rd_addr;
   assign instr_valid     = r_valid;
   assign instr_out       = r_instr_out;
   assign instr_pc        = r_instr_pc;
   assign fetch_fault     = r_fault;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-word instance exercises streaming, stalls,
// redirects, faults and reset; a 4-word instance exercises the end-of-ROM fault.
module tb_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, ready, redir;
   logic [31:0] redir_pc;
   logic        rd_a, valid_a, fault_a;
   logic [31:0] addr_a, out_a, pc_a;
   logic [31:0] rom_q_a;
   logic [2:0]  st_a;

   logic        rst_b, ready_b, redir_b;
   logic [31:0] redir_pc_b;
   logic        rd_b, valid_b, fault_b;
   logic [31:0] addr_b, out_b, pc_b;
   logic [31:0] rom_q_b;
   logic [2:0]  st_b;
   logic        bad_read_b;

   logic [31:0] mem [0:63];
   logic [31:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(32)) u_dut_a (
      .clk(clk), .reset(reset), .rom_read_enable(rd_a), .rom_address(addr_a),
      .rom_data_in(rom_q_a), .redirect_valid(redir), .redirect_pc(redir_pc),
      .instr_valid(valid_a), .instr_ready(ready), .instr_out(out_a),
      .instr_pc(pc_a), .fetch_fault(fault_a), .o_dbg_state(st_a)
   );

   fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(4)) u_dut_b (
      .clk(clk), .reset(rst_b), .rom_read_enable(rd_b), .rom_address(addr_b),
      .rom_data_in(rom_q_b), .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
      .instr_valid(valid_b), .instr_ready(ready_b), .instr_out(out_b),
      .instr_pc(pc_b), .fetch_fault(fault_b), .o_dbg_state(st_b)
   );

   // ROM models with registered read data.
   always @(posedge clk) begin
      if (rd_a) rom_q_a <= (addr_a < 32'd64) ? mem[addr_a[5:0]] : 32'hDEAD_BEEF;
      if (rd_b) rom_q_b <= (addr_b < 32'd64) ? mem[addr_b[5:0]] : 32'hDEAD_BEEF;
      if (rd_b && (addr_b >= 32'd4)) bad_read_b <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + 32'(i);
      reset = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
      rst_b = 1'b1; ready_b = 1'b0; redir_b = 1'b0; redir_pc_b = 32'h0;
      rom_q_a = 32'h0; rom_q_b = 32'h0; bad_read_b = 1'b0;

      // Reset values and first-fetch latency.
      repeat (3) nxt();
      #1;
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_out", out_a, 32'd0);
      chk("rst_pc", pc_a, 32'd0);
      chk("rst_fault", 32'(fault_a), 32'd0);
      chk("rst_rd", 32'(rd_a), 32'd0);
      chk("rst_state", 32'(st_a), 32'd0);
      reset = 1'b0;
      #1;
      chk("c1_valid", 32'(valid_a), 32'd0);
      chk("c1_rd", 32'(rd_a), 32'd0);
      nxt(); #1;
      chk("c2_rd", 32'(rd_a), 32'd1);
      chk("c2_addr", addr_a, 32'd0);
      chk("c2_valid", 32'(valid_a), 32'd0);
      nxt(); #1;
      chk("c3_valid", 32'(valid_a), 32'd0);
      chk("c3_rd", 32'(rd_a), 32'd0);
      nxt();

      // Streaming with ready high: one instruction every second cycle.
      for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + 32'(k));
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("str_valid", 32'(valid_a), 32'd1);
         chk("str_pc", pc_a, 32'(4 * k));
         chk("str_out", out_a, exp_q.pop_front());
         chk("str_rd", 32'(rd_a), 32'd1);
         chk("str_addr", addr_a, 32'(k + 1));
         nxt(); #1;
         chk("str_gap", 32'(valid_a), 32'd0);
         nxt();
      end

      // Stall at pc 0x10 for five cycles.
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_valid", 32'(valid_a), 32'd1);
         chk("stall_out", out_a, 32'hA4);
         chk("stall_pc", pc_a, 32'h10);
         chk("stall_rd", 32'(rd_a), 32'd0);
         nxt();
      end
      ready = 1'b1;
      #1;
      chk("unstall_rd", 32'(rd_a), 32'd1);
      chk("unstall_addr", addr_a, 32'd5);
      nxt(); nxt();
      ready = 1'b0;
      #1;
      chk("unstall_pc", pc_a, 32'h14);
      chk("unstall_out", out_a, 32'hA5);
      nxt();

      // Redirect to 0x10 during RESP of pc 0x4.
      reset = 1'b1; nxt();
      reset = 1'b0; ready = 1'b1;
      nxt(); nxt(); nxt();
      #1;
      chk("rdr_first_pc", pc_a, 32'h0);
      chk("rdr_first_out", out_a, 32'hA0);
      nxt();
      redir = 1'b1; redir_pc = 32'h10;
      #1;
      chk("rdr_resp_rd", 32'(rd_a), 32'd0);
      chk("rdr_resp_valid", 32'(valid_a), 32'd0);
      nxt();
      redir = 1'b0;
      #1;
      chk("rdr_req_valid", 32'(valid_a), 32'd0);
      chk("rdr_req_rd", 32'(rd_a), 32'd1);
      chk("rdr_req_addr", addr_a, 32'd4);
      nxt(); #1;
      chk("rdr_resp2_valid", 32'(valid_a), 32'd0);
      nxt();
      ready = 1'b0;
      #1;
      chk("rdr_valid", 32'(valid_a), 32'd1);
      chk("rdr_pc", pc_a, 32'h10);
      chk("rdr_out", out_a, 32'hA4);
      nxt();

      // Reach HOLD at pc 0x8, then reset there.
      redir = 1'b1; redir_pc = 32'h8;
      #1;
      chk("hold_rdr_rd", 32'(rd_a), 32'd0);
      nxt();
      redir = 1'b0;
      nxt(); nxt();
      #1;
      chk("pre_rst_valid", 32'(valid_a), 32'd1);
      chk("pre_rst_pc", pc_a, 32'h8);
      chk("pre_rst_out", out_a, 32'hA2);
      reset = 1'b1; ready = 1'b1;
      #1;
      chk("rst_forces_rd", 32'(rd_a), 32'd0);
      nxt(); #1;
      chk("midrst_valid", 32'(valid_a), 32'd0);
      chk("midrst_pc", pc_a, 32'h0);
      chk("midrst_out", out_a, 32'h0);
      reset = 1'b0;
      nxt(); nxt(); nxt();
      ready = 1'b0;
      #1;
      chk("restart_valid", 32'(valid_a), 32'd1);
      chk("restart_pc", pc_a, 32'h0);
      chk("restart_out", out_a, 32'hA0);
      nxt();

      // Misaligned redirect faults and the stage stays halted.
      redir = 1'b1; redir_pc = 32'h6;
      nxt();
      redir_pc = 32'h10; ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("halt_fault", 32'(fault_a), 32'd1);
         chk("halt_valid", 32'(valid_a), 32'd0);
         chk("halt_rd", 32'(rd_a), 32'd0);
         chk("halt_state", 32'(st_a), 32'd4);
         nxt();
      end
      redir = 1'b0;

      // Four-word ROM: accepting pc 0xC faults without reading word 4.
      ready_b = 1'b1;
      rst_b = 1'b0;
      nxt(); nxt(); nxt();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("b_valid", 32'(valid_b), 32'd1);
         chk("b_pc", pc_b, 32'(4 * k));
         chk("b_out", out_b, 32'hA0 + 32'(k));
         chk("b_rd", 32'(rd_b), (k < 3) ? 32'd1 : 32'd0);
         nxt();
         if (k < 3) nxt();
      end
      #1;
      chk("b_fault", 32'(fault_b), 32'd1);
      chk("b_end_valid", 32'(valid_b), 32'd0);
      chk("b_end_rd", 32'(rd_b), 32'd0);
      nxt(); nxt();
      chk("b_no_read_word4", 32'(bad_read_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
